// File: rtl/mux_nto1_seq.sv
// mux_nto1_seq
//   N-to-1, WIDTH-bit registered data mux with break-before-make channel
//   switching. A select change arrives over a valid/ready handshake; the
//   output is held at IDLE_VAL (out_valid=0) for DEAD cycles plus one
//   reconnect cycle, so no mixed word ever reaches the downstream stage.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   in         packed channels, channel k = in[k*WIDTH +: WIDTH]
//   sel_req    requested channel
//   sel_valid  request present
//   sel_ready  high only while passing data (request accepted on valid&&ready)
//   out        registered mux output
//   out_valid  out carries live channel data
//   cur_sel    currently connected channel
//   sel_err    one-cycle pulse after accepting an out-of-range request
//   switch_cnt (MUX_SWITCH_CNT_EN only) saturating count of completed switches
//
// Build option: define MUX_SWITCH_CNT_EN to add the switch_cnt port/counter.
module mux_nto1_seq #(
  parameter int                NUM_IN   = 4,
  parameter int                WIDTH    = 8,
  parameter int                DEAD     = 2,
  parameter logic [WIDTH-1:0]  IDLE_VAL = '0,
  localparam int               SW       = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in,
  input  logic [SW-1:0]           sel_req,
  input  logic                    sel_valid,
  output logic                    sel_ready,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  output logic [SW-1:0]           cur_sel,
  output logic                    sel_err
`ifdef MUX_SWITCH_CNT_EN
  ,
  output logic [15:0]             switch_cnt
`endif
);

  localparam int CW = $clog2(DEAD + 1);

  typedef enum logic [1:0] {PASS, BREAK, MAKE} state_t;

  state_t                       state;
  logic [SW-1:0]                pending;
  logic [CW-1:0]                dcnt;
  logic [NUM_IN-1:0][WIDTH-1:0] ch;
  logic                         req_oob;
  logic                         accept;

  assign ch        = in;
  assign sel_ready = (state == PASS);
  assign accept    = sel_valid && sel_ready;
  // Compare at 32 bits so a power-of-two NUM_IN does not wrap the bound to 0.
  assign req_oob   = 32'(sel_req) >= NUM_IN;

  // ch is only ever indexed by cur_sel, which only takes range-checked values,
  // so an undefined or out-of-range sel_req can never reach the data path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PASS;
      cur_sel   <= '0;
      pending   <= '0;
      dcnt      <= '0;
      out       <= IDLE_VAL;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
`ifdef MUX_SWITCH_CNT_EN
      switch_cnt <= '0;
`endif
    end else begin
      sel_err <= 1'b0;
      case (state)
        PASS: begin
          out       <= ch[cur_sel];
          out_valid <= 1'b1;
          if (accept) begin
            if (req_oob) begin
              sel_err <= 1'b1;
            end else if (sel_req != cur_sel) begin
              // Break on the accepting edge so the old channel never shows
              // again once the change has been committed.
              pending   <= sel_req;
              dcnt      <= '0;
              state     <= BREAK;
              out       <= IDLE_VAL;
              out_valid <= 1'b0;
            end
          end
        end
        BREAK: begin
          out       <= IDLE_VAL;
          out_valid <= 1'b0;
          if (dcnt == CW'(DEAD - 1)) begin
            cur_sel <= pending;
            state   <= MAKE;
`ifdef MUX_SWITCH_CNT_EN
            if (switch_cnt != 16'hFFFF) switch_cnt <= switch_cnt + 16'd1;
`endif
          end else begin
            dcnt <= dcnt + CW'(1);
          end
        end
        MAKE: begin
          out       <= ch[cur_sel];
          out_valid <= 1'b1;
          state     <= PASS;
        end
        default: begin
          state     <= PASS;
          out       <= IDLE_VAL;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nto1_seq.sv
// tb_mux_nto1_seq
//   Scoreboard bench for mux_nto1_seq. Each cycle the expected post-edge
//   outputs are derived from a countdown model of the switch timing and
//   pushed into a queue; after the edge the entry is popped and compared.
//   NUM_IN=5 gives a 3-bit select so out-of-range requests are reachable.
module tb_mux_nto1_seq;

  localparam int               NUM_IN   = 5;
  localparam int               WIDTH    = 8;
  localparam int               DEAD     = 2;
  localparam logic [WIDTH-1:0] IDLE_VAL = 8'hA5;
  localparam int               SW       = $clog2(NUM_IN);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_IN*WIDTH-1:0] din = '0;
  logic [SW-1:0]           sel_req = '0;
  logic                    sel_valid = 1'b0;
  logic                    sel_ready;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic [SW-1:0]           cur_sel;
  logic                    sel_err;
`ifdef MUX_SWITCH_CNT_EN
  logic [15:0]             switch_cnt;
`endif

  always #5 clk = ~clk;

  mux_nto1_seq #(
    .NUM_IN(NUM_IN), .WIDTH(WIDTH), .DEAD(DEAD), .IDLE_VAL(IDLE_VAL)
  ) dut (
    .clk(clk), .rst(rst), .in(din), .sel_req(sel_req), .sel_valid(sel_valid),
    .sel_ready(sel_ready), .out(out), .out_valid(out_valid),
    .cur_sel(cur_sel), .sel_err(sel_err)
`ifdef MUX_SWITCH_CNT_EN
    , .switch_cnt(switch_cnt)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             ov;
    logic [SW-1:0]    sel;
    logic             rdy;
    logic             err;
    logic [15:0]      cnt;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // model: connected channel, pending channel, non-PASS cycles left, switch count
  logic [SW-1:0] m_sel  = '0;
  logic [SW-1:0] m_pend = '0;
  int            m_left = 0;
  logic [15:0]   m_cnt  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] chan(input logic [NUM_IN*WIDTH-1:0] d, input int k);
    return d[k*WIDTH +: WIDTH];
  endfunction

  task automatic model_reset();
    m_sel = '0; m_pend = '0; m_left = 0; m_cnt = '0;
    sb.delete();
  endtask

  // Drive one cycle at the falling edge, predict, then compare after the rise.
  task automatic step(input logic [NUM_IN*WIDTH-1:0] d, input logic v, input logic [SW-1:0] req);
    exp_t e;
    @(negedge clk);
    din = d; sel_valid = v; sel_req = req;
    e.err = 1'b0;
    if (m_left == 0) begin
      if (v && int'(req) >= NUM_IN) begin
        e.err = 1'b1;
        e.out = chan(d, int'(m_sel)); e.ov = 1'b1;
      end else if (v && req != m_sel) begin
        m_pend = req; m_left = DEAD + 1;
        e.out = IDLE_VAL; e.ov = 1'b0;
      end else begin
        e.out = chan(d, int'(m_sel)); e.ov = 1'b1;
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        m_sel = m_pend;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      if (m_left == 0) begin
        e.out = chan(d, int'(m_sel)); e.ov = 1'b1;
      end else begin
        e.out = IDLE_VAL; e.ov = 1'b0;
      end
    end
    e.sel = m_sel;
    e.rdy = (m_left == 0);
    e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("out", 32'(out), 32'(e.out));
      chk("out_valid", 32'(out_valid), 32'(e.ov));
      chk("cur_sel", 32'(cur_sel), 32'(e.sel));
      chk("sel_ready", 32'(sel_ready), 32'(e.rdy));
      chk("sel_err", 32'(sel_err), 32'(e.err));
`ifdef MUX_SWITCH_CNT_EN
      chk("switch_cnt", 32'(switch_cnt), 32'(e.cnt));
`endif
    end
  endtask

  function automatic logic [NUM_IN*WIDTH-1:0] rnd_in();
    logic [NUM_IN*WIDTH-1:0] r;
    for (int k = 0; k < NUM_IN; k++) r[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    return r;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_out"}, 32'(out), 32'(IDLE_VAL));
    chk({tag, "_ov"}, 32'(out_valid), 32'd0);
    chk({tag, "_sel"}, 32'(cur_sel), 32'd0);
    chk({tag, "_err"}, 32'(sel_err), 32'd0);
`ifdef MUX_SWITCH_CNT_EN
    chk({tag, "_cnt"}, 32'(switch_cnt), 32'd0);
`endif
  endtask

  // Request a switch and hold the request until the mux is back in PASS.
  task automatic switch_to(input logic [SW-1:0] ch);
    step(rnd_in(), 1'b1, ch);
    for (int i = 0; i < DEAD + 2; i++) step(rnd_in(), 1'b1, ch);
    step(rnd_in(), 1'b0, '0);
  endtask

  initial begin
    logic [NUM_IN*WIDTH-1:0] d;

    // reset with live inputs
    din = rnd_in();
    #12;
    check_reset_state("rst");
    chk("rst_ready", 32'(sel_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // pass-through ramp on channel 0 (first edge after release included)
    for (int i = 0; i < 6; i++) begin
      d = rnd_in();
      d[WIDTH-1:0] = WIDTH'(8'h10 + i);
      step(d, 1'b0, '0);
    end

    // 0 -> 2 switch, then idle cycles
    switch_to(3'd2);
    for (int i = 0; i < 3; i++) step(rnd_in(), 1'b0, '0);

    // same-channel request: no break
    for (int i = 0; i < 3; i++) step(rnd_in(), 1'b1, 3'd2);

    // out-of-range request
    step(rnd_in(), 1'b1, 3'd5);
    step(rnd_in(), 1'b0, '0);
    step(rnd_in(), 1'b1, 3'd7);
    step(rnd_in(), 1'b0, '0);

    // chain of switches including the highest channel
    switch_to(3'd4);
    switch_to(3'd1);
    switch_to(3'd0);
    switch_to(3'd3);

    // random traffic
    for (int i = 0; i < 300; i++)
      step(rnd_in(), ($urandom_range(0, 2) == 0), SW'($urandom_range(0, 7)));

    // reset in the middle of a break
    if (m_left != 0) begin
      for (int i = 0; i < DEAD + 2; i++) step(rnd_in(), 1'b0, '0);
    end
    step(rnd_in(), 1'b1, (m_sel == 3'd1) ? 3'd3 : 3'd1);
    step(rnd_in(), 1'b1, (m_pend));
    chk("pre_rst_in_break", 32'(sel_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_state("rst_break");
    @(negedge clk);
    rst = 1'b0;
    sel_valid = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) step(rnd_in(), 1'b0, '0);
    switch_to(3'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
